memory_bus_arbiter: RTL and testbench
=====================================

// Module: memory_bus_arbiter
// PURPOSE
//  Shares the single Controller core memory bus between a core's instruction-fetch port and data port.
//  One transaction is in flight at a time; the owner's request is held on the memory side until
//  memory_response arrives, then a one-cycle registered response goes back to the owner.
//  A watchdog aborts transactions that never get a response. Sits between Core and Controller.
// PARAMETERS
//  BUS_WIDTH       32      address/data width
//  TIMEOUT_CYCLES  1024    cycles to wait for mem_response before abort; 0 = watchdog disabled
//  ERROR_DATA      32'hDEADBEEF  read data returned on timeout abort
// PORTS
//  clk             in   1         single clock
//  reset           in   1         synchronous, active-low reset
//  i_read          in   1         instr port read request (level, held until i_response)
//  i_address       in   BUS_WIDTH instr port address
//  i_read_data     out  BUS_WIDTH instr port read data, valid while i_response=1
//  i_response      out  1         instr port completion pulse (1 cycle)
//  d_read/d_write  in   1         data port read/write request (level, held until d_response)
//  d_address       in   BUS_WIDTH data port address
//  d_write_data    in   BUS_WIDTH data port write data
//  d_read_data     out  BUS_WIDTH data port read data, valid while d_response=1
//  d_response      out  1         data port completion pulse (1 cycle)
//  mem_read        out  1         memory-side read strobe (level)
//  mem_write       out  1         memory-side write strobe (level)
//  mem_address     out  BUS_WIDTH memory-side address
//  mem_write_data  out  BUS_WIDTH memory-side write data
//  mem_read_data   in   BUS_WIDTH memory-side read data
//  mem_response    in   1         memory-side completion (sampled only while BUSY)
//  grant           out  2         current owner: 00 none, 01 instr, 10 data
//  timeout_flag    out  1         sticky: set on any watchdog abort, cleared only by reset
// BEHAVIOUR
//  - Reset (reset=0 at posedge): state IDLE, all outputs 0, watchdog counter 0, RR pointer -> data.
//    Reset mid-transaction abandons it; no response pulse is issued; strobes are low the next cycle.
//  - States: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: sample i_read, d_read|d_write. If none, stay. If one, grant it. If both, arbitrate:
//    fixed priority = data wins. Latch owner, address, write data, op into registers; go BUSY.
//  - Data port with d_read and d_write both high: executes as a write.
//  - BUSY: mem_read/mem_write held high from the cycle after grant until the mem_response cycle.
//    Registered address/data are driven; later requester input changes are ignored.
//    On mem_response=1: capture mem_read_data, drop strobes, go RESP.
//  - Watchdog: the counter increments each BUSY cycle without a response.
//    When it reaches TIMEOUT_CYCLES: abort, capture ERROR_DATA, set timeout_flag, go RESP.
//    mem_response arriving in the same cycle as the timeout wins; the timeout is not flagged.
//  - RESP: owner's *_response=1 with captured read data for exactly one cycle. Go IDLE.
//    Non-owner response and read data stay 0. The requester must drop its request before the next IDLE cycle.
//  - Latency: request seen in IDLE at cycle N -> strobe high at N+1. mem_response at cycle M -> owner response at M+1.
//    New arbitration at M+2. Minimum 3 cycles per transaction with a zero-wait memory.
//  - grant is valid in BUSY and RESP, 00 in IDLE. Outputs are all registered; no combinational path from requester to memory.
// CONFIGURATION
//  ARBITER_ROUND_ROBIN_EN defined: on simultaneous requests the port not granted last wins.
//    The RR pointer updates only on a granted transaction.
//  ARBITER_ROUND_ROBIN_EN undefined: fixed priority, data port always wins ties; no pointer logic is synthesised.
// TESTING
//  - Single instr read, mem_response 2 cycles after the strobe, mem_read_data=32'h00000013:
//    i_response pulses 1 cycle with i_read_data=32'h00000013; grant=01 during BUSY.
//  - Data write addr 32'h100, data 32'hCAFEF00D:
//    mem_write=1, mem_address=32'h100, mem_write_data=32'hCAFEF00D until mem_response; then d_response=1.
//  - i_read and d_read asserted together on 4 back-to-back transactions:
//    fixed priority gives D,D,D,D (instr starves while d held).
//    With ARBITER_ROUND_ROBIN_EN: D,I,D,I.
//  - TIMEOUT_CYCLES=8, memory never responds:
//    strobe high 8 cycles, then owner response with read data 32'hDEADBEEF; timeout_flag=1 until reset.
//  - reset=0 asserted during BUSY: next cycle mem_read=mem_write=0, grant=00, no *_response pulse.
//    A request after release is serviced normally.
//  - mem_response coincides with the timeout cycle: real mem_read_data is returned; timeout_flag stays 0.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter for the single core memory bus, with a response watchdog.
// Optional ARBITER_ROUND_ROBIN_EN alternates tie winners; the default build gives the data port fixed priority.
module memory_bus_arbiter #(
    parameter int                   BUS_WIDTH      = 32,
    parameter int                   TIMEOUT_CYCLES = 1024,
    parameter logic [BUS_WIDTH-1:0] ERROR_DATA     = BUS_WIDTH'(32'hDEADBEEF)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_read,
    input  logic [BUS_WIDTH-1:0] i_address,
    output logic [BUS_WIDTH-1:0] i_read_data,
    output logic                 i_response,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [BUS_WIDTH-1:0] d_address,
    input  logic [BUS_WIDTH-1:0] d_write_data,
    output logic [BUS_WIDTH-1:0] d_read_data,
    output logic                 d_response,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BUS_WIDTH-1:0] mem_address,
    output logic [BUS_WIDTH-1:0] mem_write_data,
    input  logic [BUS_WIDTH-1:0] mem_read_data,
    input  logic                 mem_response,
    output logic [1:0]           grant,
    output logic                 timeout_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // Handshake: requests are levels held from the IDLE sample until the owner's one-cycle
    // *_response pulse; mem_response is only honoured while BUSY with a strobe raised.
    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            req_i;
    logic            req_d;
    logic            pick_d;
    logic            wd_expired;
    logic            finish;
    logic [BUS_WIDTH-1:0] resp_data;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic rr_data_next;  // 1: data port wins the next tie
    assign pick_d = req_d && (!req_i || rr_data_next);
`else
    assign pick_d = req_d;
`endif

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
    assign finish     = mem_response || wd_expired;
    // A real response in the watchdog's final cycle takes precedence over the abort.
    assign resp_data  = mem_response ? mem_read_data : ERROR_DATA;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            wd_cnt         <= '0;
            grant          <= 2'b00;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            i_response     <= 1'b0;
            i_read_data    <= '0;
            d_response     <= 1'b0;
            d_read_data    <= '0;
            timeout_flag   <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
            rr_data_next   <= 1'b1;
`endif
        end else begin
            i_response  <= 1'b0;
            i_read_data <= '0;
            d_response  <= 1'b0;
            d_read_data <= '0;
            case (state)
                IDLE: begin
                    if (req_i || req_d) begin
                        state          <= BUSY;
                        wd_cnt         <= '0;
                        grant          <= pick_d ? 2'b10 : 2'b01;
                        mem_write      <= pick_d && d_write;
                        mem_read       <= !(pick_d && d_write);
                        mem_address    <= pick_d ? d_address : i_address;
                        mem_write_data <= pick_d ? d_write_data : '0;
`ifdef ARBITER_ROUND_ROBIN_EN
                        rr_data_next   <= !pick_d;
`endif
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state     <= RESP;
                        wd_cnt    <= '0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (!mem_response) begin
                            timeout_flag <= 1'b1;
                        end
                        if (grant[1]) begin
                            d_response  <= 1'b1;
                            d_read_data <= resp_data;
                        end else begin
                            i_response  <= 1'b1;
                            i_read_data <= resp_data;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed vector table, reset-abort sequence, then random
// transactions checked against a per-transaction reference model (watchdog set to 8 cycles).
module tb_memory_bus_arbiter;

    localparam int          TO      = 8;
    localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_read_data;
    logic        i_response;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_write_data;
    logic [31:0] d_read_data;
    logic        d_response;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_response;
    logic [1:0]  grant;
    logic        timeout_flag;

    memory_bus_arbiter #(
        .BUS_WIDTH      (32),
        .TIMEOUT_CYCLES (TO),
        .ERROR_DATA     (ERR_VAL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_read         (i_read),
        .i_address      (i_address),
        .i_read_data    (i_read_data),
        .i_response     (i_response),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_address      (d_address),
        .d_write_data   (d_write_data),
        .d_read_data    (d_read_data),
        .d_response     (d_response),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_response   (mem_response),
        .grant          (grant),
        .timeout_flag   (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic        dr;
        logic        dw;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        int          wait_n;   // extra strobe cycles before memory answers
        logic [31:0] rdata;
        logic [1:0]  e_grant;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        int          e_strobes;
        logic [31:0] e_data;
        logic        e_flag;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        m_last_d = 1'b0;  // model: last granted port was data
    logic        m_flag   = 1'b0;
    vec_t        tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da, dwd,
                                input int wait_n, input logic [31:0] rdata,
                                input logic [1:0] e_grant, input logic e_wr,
                                input logic [31:0] e_addr, input int e_strobes,
                                input logic [31:0] e_data, input logic e_flag);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.dwd = dwd;
        v.wait_n = wait_n; v.rdata = rdata; v.e_grant = e_grant; v.e_wr = e_wr;
        v.e_addr = e_addr; v.e_wd = dwd; v.e_strobes = e_strobes; v.e_data = e_data;
        v.e_flag = e_flag;
        return v;
    endfunction

    // Reference model: whole-transaction outcome from the arbitration and watchdog rules.
    function automatic vec_t model_vec(input logic ir, dr, dw, input logic [31:0] ia, da, dwd,
                                       input int wait_n, input logic [31:0] rdata);
        vec_t v;
        logic take_d;
        logic late;
        if (!(dr || dw))  take_d = 1'b0;
        else if (!ir)     take_d = 1'b1;
        else begin
`ifdef ARBITER_ROUND_ROBIN_EN
            take_d = !m_last_d;
`else
            take_d = 1'b1;
`endif
        end
        late        = (wait_n + 1 > TO);
        v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.dwd = dwd;
        v.wait_n    = wait_n;
        v.rdata     = rdata;
        v.e_grant   = take_d ? 2'b10 : 2'b01;
        v.e_wr      = take_d && dw;
        v.e_addr    = take_d ? da : ia;
        v.e_wd      = dwd;
        v.e_strobes = late ? TO : wait_n + 1;
        v.e_data    = late ? ERR_VAL : rdata;
        v.e_flag    = m_flag || late;
        return v;
    endfunction

    // Starts and ends at a negedge in an IDLE cycle.
    task automatic run_txn(input vec_t v);
        int   strobes = 0;
        logic got     = 1'b0;
        logic [31:0] act;
        i_read = v.ir; d_read = v.dr; d_write = v.dw;
        i_address = v.ia; d_address = v.da; d_write_data = v.dwd;
        exp_q.push_back(v.e_data);
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            mem_response  = 1'b0;
            mem_read_data = $urandom;
            if (c == 0) chk("strobe_latency", {31'b0, mem_read | mem_write}, 32'd1);
            if (mem_read || mem_write) begin
                strobes++;
                chk("grant_busy", {30'b0, grant}, {30'b0, v.e_grant});
                chk("mem_write", {31'b0, mem_write}, {31'b0, v.e_wr});
                chk("mem_read", {31'b0, mem_read}, {31'b0, !v.e_wr});
                chk("mem_address", mem_address, v.e_addr);
                if (v.e_wr) chk("mem_write_data", mem_write_data, v.e_wd);
                i_address = $urandom; d_address = $urandom; d_write_data = $urandom;
                if (strobes == v.wait_n + 1) begin
                    mem_response  = 1'b1;
                    mem_read_data = v.rdata;
                end
            end else if (i_response || d_response) begin
                got = 1'b1;
                act = v.e_grant[1] ? d_read_data : i_read_data;
                chk("resp_port", {30'b0, d_response, i_response}, {30'b0, v.e_grant});
                chk("resp_data", act, exp_q.pop_front());
                chk("nonowner_data", v.e_grant[1] ? i_read_data : d_read_data, 32'd0);
                chk("grant_resp", {30'b0, grant}, {30'b0, v.e_grant});
                chk("timeout_flag", {31'b0, timeout_flag}, {31'b0, v.e_flag});
            end
        end
        chk("resp_seen", {31'b0, got}, 32'd1);
        chk("strobe_cycles", strobes, v.e_strobes);
        if (!got) void'(exp_q.pop_front());
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        chk("idle_after", {28'b0, grant, i_response, d_response}, 32'd0);
        chk("idle_strobe", {30'b0, mem_read, mem_write}, 32'd0);
        m_last_d = (v.e_grant == 2'b10);
        m_flag   = v.e_flag;
    endtask

    initial begin
        vec_t v;
        logic ir, dr, dw;
        reset = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_write_data = '0;
        mem_read_data = '0; mem_response = 1'b0;

        tbl[0] = mk(0, 0, 1, 32'h0, 32'h100, 32'hCAFEF00D, 1, 32'h0,
                    2'b10, 1, 32'h100, 2, 32'h0, 0);
        tbl[1] = mk(1, 0, 0, 32'h400, 32'h0, 32'h0, 2, 32'h00000013,
                    2'b01, 0, 32'h400, 3, 32'h00000013, 0);
        for (int k = 0; k < 4; k++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            if (k % 2 == 1)
                tbl[2+k] = mk(1, 1, 0, 32'h200 + k, 32'h300 + k, 32'h0, 0, 32'h1000 + k,
                              2'b01, 0, 32'h200 + k, 1, 32'h1000 + k, 0);
            else
`endif
                tbl[2+k] = mk(1, 1, 0, 32'h200 + k, 32'h300 + k, 32'h0, 0, 32'h1000 + k,
                              2'b10, 0, 32'h300 + k, 1, 32'h1000 + k, 0);
        end
        tbl[6] = mk(0, 1, 1, 32'h0, 32'h50, 32'h12345678, 0, 32'h77,
                    2'b10, 1, 32'h50, 1, 32'h77, 0);
        tbl[7] = mk(1, 0, 0, 32'h60, 32'h0, 32'h0, 7, 32'hA5A5A5A5,
                    2'b01, 0, 32'h60, 8, 32'hA5A5A5A5, 0);
        tbl[8] = mk(0, 1, 0, 32'h0, 32'h70, 32'h0, 99, 32'h0,
                    2'b10, 0, 32'h70, 8, ERR_VAL, 1);
        tbl[9] = mk(1, 0, 0, 32'h80, 32'h0, 32'h0, 0, 32'h9,
                    2'b01, 0, 32'h80, 1, 32'h9, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_grant", {30'b0, grant}, 32'd0);
        chk("rst_resp", {30'b0, i_response, d_response}, 32'd0);
        chk("rst_flag", {31'b0, timeout_flag}, 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        reset = 1'b1;

        for (int n = 0; n < 10; n++) run_txn(tbl[n]);

        // Reset while BUSY abandons the transaction and clears the sticky flag.
        d_read = 1'b1; d_address = 32'h40;
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, mem_read}, 32'd1);
        reset = 1'b0; d_read = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("midrst_grant", {30'b0, grant}, 32'd0);
        chk("midrst_resp", {30'b0, i_response, d_response}, 32'd0);
        chk("midrst_flag", {31'b0, timeout_flag}, 32'd0);
        reset = 1'b1;
        m_last_d = 1'b0;
        m_flag   = 1'b0;
        run_txn(model_vec(1, 0, 0, 32'h44, 32'h0, 32'h0, 1, 32'h5151));

        for (int n = 0; n < 40; n++) begin
            ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
            if (!(ir || dr || dw)) ir = 1'b1;
            v = model_vec(ir, dr, dw, $urandom, $urandom, $urandom,
                          $urandom_range(0, 10), $urandom);
            run_txn(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
